decoder_proj_stream: RTL and testbench
======================================

Name: decoder_proj_stream

Overview:
- Parametrised successor to the single-shot 7-bit io_in decoder.
- Samples a pad-level command word and debounces it over STABLE_CYC cycles.
- Each accepted command is queued in a DEPTH-entry FIFO and presented as a one-hot decode through a valid/ready handshake.
- Also drives a registered latched decode vector, a registered one-cycle pulse vector, and a saturating drop counter. Sits between the user io pads and downstream decoder consumers.

Parameters:
- IN_W, 7: width of io_in. Bit IN_W-1 = en, bit IN_W-2 = mode, bits [SEL_W-1:0] = sel. Any other bits are ignored.
- SEL_W, 5: select width. Decode width is 2**SEL_W. Requires SEL_W <= IN_W-2.
- STABLE_CYC, 3: consecutive identical samples needed to accept a code. Must be >= 1.
- DEPTH, 4: FIFO entries. Must be a power of 2 and >= 2.

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- io_in  in  IN_W  command word; treated as already synchronised.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  consumer accepts head when dec_valid && dec_ready.
- dec_onehot  out  2**SEL_W  1 << head.sel; all zeros when dec_valid=0.
- dec_mode  out  1  head.mode; 0 when dec_valid=0.
- lat_out  out  2**SEL_W  latched decode.
- pulse_out  out  2**SEL_W  one-cycle decode pulse.
- drop_cnt  out  8  saturating count of commands dropped on FIFO full.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (wb_rst_i=1 at an edge):
  - FSM goes to IDLE; FIFO is emptied; sample register and stability counter clear.
  - All outputs read 0: dec_valid, dec_onehot, dec_mode, lat_out, pulse_out, drop_cnt, busy.
  - Reset mid-operation discards queued entries; no pulse is emitted.
- Sampling:
  - smp_q <= io_in on every edge.
  - cnt resets to 1 when io_in != smp_q, else increments, saturating at STABLE_CYC.
- Debounce FSM states:
  - IDLE: en=0 in the sample, or a code is not yet stable.
  - COUNT: en=1, code still settling.
  - HELD: code accepted, waiting for a change.
- Transitions:
  - IDLE -> COUNT when the sampled en=1.
  - COUNT -> HELD on the STABLE_CYC-th consecutive edge sampling an identical word with en=1. That edge pushes {mode, sel}.
  - COUNT or HELD -> IDLE when sampled en=0.
  - HELD -> COUNT when the sampled word changes with en=1.
  - A held code never re-pushes. Re-arming requires a change of any bit or an en drop.
  - STABLE_CYC=1: a push occurs on the first edge that samples the word.
- Latency: word applied before edge k and held. Push happens at edge k+STABLE_CYC-1; dec_valid=1 in the following cycle. There is no same-cycle bypass.
- FIFO:
  - A push when full with no pop in the same cycle is dropped, and drop_cnt increments, saturating at 255.
  - Full with a simultaneous pop: push accepted, occupancy unchanged.
  - Empty with a simultaneous push: entry visible next cycle.
  - Head outputs are stable while dec_valid && !dec_ready.
  - Pointers wrap modulo DEPTH.
- On handshake (dec_valid && dec_ready):
  - If head.mode=1: lat_out <= dec_onehot at that edge (replace, not OR). pulse_out <= 0.
  - If head.mode=0: pulse_out <= dec_onehot for exactly one cycle, then 0. lat_out is unchanged.
  - No handshake in a cycle: pulse_out <= 0.
- dec_ready asserted while dec_valid=0 has no effect.

Test Plan:
- Reset, then io_in=7'b1110001 held from before edge 1 (defaults) -> push at edge 3; dec_valid=1, dec_onehot=32'h0002_0000, dec_mode=1. With dec_ready=1: lat_out=32'h0002_0000 after the handshake edge, pulse_out stays 0.
- io_in=7'b1000011 held, dec_ready=1 -> single push; pulse_out=32'h0000_0008 for exactly one cycle; no second push while the word is held.
- Toggle io_in bit0 every 2 cycles with en=1 -> no push, busy=1, dec_valid=0; then hold the word 3 cycles -> exactly one push.
- dec_ready=0, push 6 distinct codes -> FIFO holds the first 4 in order; drop_cnt=2. Then dec_ready=1 -> 4 handshakes in order, dec_valid then 0.
- FIFO full and a push coinciding with a pop -> push accepted, drop_cnt unchanged, order preserved.
- Assert wb_rst_i for one cycle with 3 entries queued and lat_out nonzero -> next cycle all outputs 0; the same word then needs a full STABLE_CYC samples before it is accepted again.

Source files
------------

// File: rtl/decoder_proj_stream.sv
// Debounced command decoder: a stable io_in word is queued in a small FIFO and presented as a
// one-hot decode over valid/ready, with latched and pulsed decode vectors and a drop counter.
module decoder_proj_stream #(
  parameter int unsigned IN_W       = 7,
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned STABLE_CYC = 3,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [IN_W-1:0]       io_in,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [2**SEL_W-1:0]   dec_onehot,
  output logic                  dec_mode,
  output logic [2**SEL_W-1:0]   lat_out,
  output logic [2**SEL_W-1:0]   pulse_out,
  output logic [7:0]            drop_cnt,
  output logic                  busy
);

  localparam int unsigned DecW = 2**SEL_W;
  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StCount, StHeld} state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     smp_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                en_in, same, push;

  logic [SEL_W:0]      mem_q [DEPTH];
  logic [PtrW:0]       wr_q, rd_q;
  logic                empty, full, pop, push_ok, drop;
  logic [SEL_W:0]      head;

  logic [DecW-1:0]     lat_q, pulse_q;
  logic [7:0]          drop_q;

  assign en_in = io_in[IN_W-1];
  assign same  = (io_in == smp_q);

  always_comb begin
    cnt_d = CntW'(1);
    if (same) begin
      cnt_d = (cnt_q == CntW'(STABLE_CYC)) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  // A held, unchanged word never re-pushes; any change re-arms even from StHeld.
  assign push = en_in && (cnt_d == CntW'(STABLE_CYC)) && !((state_q == StHeld) && same);

  always_comb begin
    state_d = StCount;
    if (!en_in) begin
      state_d = StIdle;
    end else if (push || ((state_q == StHeld) && same)) begin
      state_d = StHeld;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      smp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= io_in;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO with one extra pointer bit to tell full from empty.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
  assign pop     = dec_valid && dec_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem_q[rd_q[PtrW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem_q[wr_q[PtrW-1:0]] <= {io_in[IN_W-2], io_in[SEL_W-1:0]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign dec_valid  = !empty;
  assign dec_onehot = dec_valid ? (DecW'(1) << head[SEL_W-1:0]) : '0;
  assign dec_mode   = dec_valid && head[SEL_W];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lat_q   <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (pop) begin
        if (head[SEL_W]) lat_q   <= dec_onehot;
        else             pulse_q <= dec_onehot;
      end
    end
  end

  assign lat_out   = lat_q;
  assign pulse_out = pulse_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_decoder_proj_stream.sv
// Scoreboard bench for decoder_proj_stream: stimulus queues expected {mode, sel} entries and a
// negedge monitor checks every handshake plus the latched and pulsed decode vectors.
module tb_decoder_proj_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  io_in;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_onehot;
  logic        dec_mode;
  logic [31:0] lat_out;
  logic [31:0] pulse_out;
  logic [7:0]  drop_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit mon_en = 1'b0;

  logic [5:0]  exp_q [$];
  logic [31:0] exp_lat   = '0;
  logic [31:0] exp_pulse = '0;

  decoder_proj_stream dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .io_in      (io_in),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_onehot (dec_onehot),
    .dec_mode   (dec_mode),
    .lat_out    (lat_out),
    .pulse_out  (pulse_out),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply a word; if keep is set the word is expected to reach the FIFO head in order.
  task automatic issue(input logic [6:0] w, input bit keep);
    io_in = w;
    if (keep) exp_q.push_back({w[5], w[4:0]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, dec_valid, 0);
    chk({tag, "_onehot"}, dec_onehot, 0);
    chk({tag, "_mode"}, dec_mode, 0);
    chk({tag, "_lat"}, lat_out, 0);
    chk({tag, "_pulse"}, pulse_out, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: compares registered vectors against the model, then predicts the next cycle.
  always @(negedge clk) begin
    logic [5:0]  e;
    logic [31:0] oh;
    if (mon_en) begin
      chk("mon_lat_out", lat_out, exp_lat);
      chk("mon_pulse_out", pulse_out, exp_pulse);
      if (rst) begin
        exp_q.delete();
        exp_lat   = '0;
        exp_pulse = '0;
      end else begin
        exp_pulse = '0;
        if (dec_valid && dec_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_entry actual=%0h expected=none", dec_onehot);
          end else begin
            e  = exp_q.pop_front();
            oh = 32'd1 << e[4:0];
            chk("mon_onehot", dec_onehot, oh);
            chk("mon_mode", dec_mode, e[5]);
            hs_cnt++;
            if (e[5]) exp_lat = oh;
            else      exp_pulse = oh;
          end
        end else if (!dec_valid) begin
          chk("mon_idle_onehot", dec_onehot, 0);
        end
      end
    end
  end

  initial begin
    int hs0;
    rst       = 1'b1;
    io_in     = '0;
    dec_ready = 1'b0;
    step(2);
    chk_all_zero("reset");

    // Mode-1 code: latched decode, three-sample latency.
    rst       = 1'b0;
    dec_ready = 1'b1;
    mon_en    = 1'b1;
    issue(7'b1110001, 1);
    step(2);
    chk("t1_valid_early", dec_valid, 0);
    step(1);
    chk("t1_valid", dec_valid, 1);
    chk("t1_onehot", dec_onehot, 32'h0002_0000);
    chk("t1_mode", dec_mode, 1);
    chk("t1_busy", busy, 1);
    step(1);
    chk("t1_lat", lat_out, 32'h0002_0000);
    chk("t1_pulse", pulse_out, 0);

    // Mode-0 code: single one-cycle pulse, no re-push while held.
    issue(7'b1000011, 1);
    step(4);
    chk("t2_pulse", pulse_out, 32'h0000_0008);
    step(1);
    chk("t2_pulse_gone", pulse_out, 0);
    step(4);
    chk("t2_no_repush", dec_valid, 0);

    // Toggling word never settles.
    for (int i = 0; i < 4; i++) begin
      io_in = (i % 2 == 1) ? 7'b1000101 : 7'b1000100;
      step(2);
      chk("t3_toggle_valid", dec_valid, 0);
      chk("t3_toggle_busy", busy, 1);
    end
    issue(7'b1000100, 1);
    step(2);
    chk("t3_hold_valid_early", dec_valid, 0);
    step(1);
    chk("t3_hold_valid", dec_valid, 1);
    io_in = '0;
    step(3);
    chk("t3_idle_busy", busy, 0);

    // Overflow: six codes into a four-entry FIFO with the consumer stalled.
    dec_ready = 1'b0;
    issue(7'b1100000, 1); step(3);
    issue(7'b1000001, 1); step(3);
    issue(7'b1100010, 1); step(3);
    issue(7'b1000011, 1); step(3);
    issue(7'b1000100, 0); step(3);
    issue(7'b1100101, 0); step(3);
    chk("t4_drop", drop_cnt, 2);
    chk("t4_valid", dec_valid, 1);
    hs0 = hs_cnt;
    dec_ready = 1'b1;
    step(6);
    chk("t4_drained", dec_valid, 0);
    chk("t4_handshakes", hs_cnt - hs0, 4);
    chk("t4_lat", lat_out, 32'h0000_0004);

    // Full FIFO with push and pop on the same edge.
    dec_ready = 1'b0;
    issue(7'b1100110, 1); step(3);
    issue(7'b1000111, 1); step(3);
    issue(7'b1101000, 1); step(3);
    issue(7'b1001001, 1); step(3);
    issue(7'b1101010, 1);
    step(2);
    dec_ready = 1'b1;
    step(1);
    dec_ready = 1'b0;
    chk("t5_drop_same", drop_cnt, 2);
    chk("t5_still_valid", dec_valid, 1);
    dec_ready = 1'b1;
    step(8);
    chk("t5_drained", dec_valid, 0);
    chk("t5_lat", lat_out, 32'h0000_0400);

    // Reset with entries queued.
    dec_ready = 1'b0;
    issue(7'b1001011, 1); step(3);
    issue(7'b1101100, 1); step(3);
    issue(7'b1001101, 1); step(3);
    chk("t6_pre_valid", dec_valid, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_all_zero("t6_post_reset");
    issue(7'b1001101, 1);
    step(2);
    chk("t6_rearm_early", dec_valid, 0);
    step(1);
    chk("t6_rearm_valid", dec_valid, 1);
    chk("t6_rearm_onehot", dec_onehot, 32'h0000_2000);
    dec_ready = 1'b1;
    step(1);
    chk("t6_pulse", pulse_out, 32'h0000_2000);
    step(3);
    chk("t6_done_valid", dec_valid, 0);
    chk("t6_queue_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
